// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Each generated round key is exported so a chained decryptor can build its own schedule.
module aes128_encrypt_core #(
    parameter int NR         = 10,
    parameter bit KEY_OUT_EN = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] secret,
    input  logic [127:0] plaintext,
    output logic [127:0] cipher,
    output logic         done,
    output logic         busy,
    output logic [127:0] roundKeyOut,
    output logic [3:0]   roundKeyIndex,
    output logic [127:0] lastRoundKey
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_encrypt_core: NR must be 10 for AES-128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        ROUND
    } fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] next_key;
    logic [127:0] mid_state;
    logic [127:0] final_state;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Word 0 takes RotWord/SubWord/Rcon; the other three words cascade from it.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        t  = w0;
        w1 = k[95:64] ^ t;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte r+4c (row r, column c) sits at bits [127-8*(r+4c) -: 8].
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = SBOX[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    always_comb begin
        next_key    = key_expand(key_reg, rcon(round));
        final_state = sub_shift(state_reg) ^ next_key;
        mid_state   = mix_columns(sub_shift(state_reg)) ^ next_key;
    end

    if (KEY_OUT_EN) begin : g_key_out
        assign roundKeyOut   = busy ? next_key : '0;
        assign roundKeyIndex = busy ? round : 4'd0;
    end else begin : g_no_key_out
        assign roundKeyOut   = '0;
        assign roundKeyIndex = 4'd0;
    end

    // NOTE: every register here, including the datapath state and key, is cleared by reset
    // so no key material survives an abandoned block; all updates are non-blocking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm          <= IDLE;
            round        <= 4'd0;
            state_reg    <= '0;
            key_reg      <= '0;
            cipher       <= '0;
            lastRoundKey <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state_reg <= plaintext ^ secret;
                        key_reg   <= secret;
                        round     <= 4'd1;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    key_reg <= next_key;
                    if (round == LAST_ROUND) begin
                        cipher       <= final_state;
                        lastRoundKey <= next_key;
                        round        <= 4'd0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        fsm          <= IDLE;
                    end else begin
                        state_reg <= mid_state;
                        round     <= round + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core: scoreboard of expected ciphers and completion cycles,
// plus an independent inverse cipher that recovers the plaintext from cipher and lastRoundKey.
module tb_aes128_encrypt_core;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] secret;
    logic [127:0] plaintext;
    logic [127:0] cipher;
    logic         done;
    logic         busy;
    logic [127:0] roundKeyOut;
    logic [3:0]   roundKeyIndex;
    logic [127:0] lastRoundKey;

    aes128_encrypt_core #(.NR(10), .KEY_OUT_EN(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .secret       (secret),
        .plaintext    (plaintext),
        .cipher       (cipher),
        .done         (done),
        .busy         (busy),
        .roundKeyOut  (roundKeyOut),
        .roundKeyIndex(roundKeyIndex),
        .lastRoundKey (lastRoundKey)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dones = 0;
    int         last_done_cyc = -1;
    logic [7:0] fsb[256];
    logic [7:0] isb[256];
    logic [7:0] rc_tab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} >> (8 - n);
        return t[7:0];
    endfunction

    // S-box derived from the GF(2^8) inverse and affine map rather than a table.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fsb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, t;
        {w0, w1, w2, w3} = k;
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        t  = {p3[23:0], p3[31:24]};
        t  = {fsb[t[31:24]], fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]]} ^ {rc, 24'h0};
        p0 = w0 ^ t;
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] first_key(input logic [127:0] k10);
        logic [127:0] k;
        k = k10;
        for (int r = 10; r >= 1; r--) k = prev_key(k, rc_tab[r-1]);
        return k;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [127:0] k10);
        logic [127:0] k[11];
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] st;
        k[10] = k10;
        for (int r = 10; r >= 1; r--) k[r-1] = prev_key(k[r], rc_tab[r-1]);
        st = ct ^ k[10];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) a[i] = st[127 - 8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    b[w + 4*c] = isb[a[w + 4*((c - w + 4) % 4)]];
            for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = b[i] ^ k[r][127 - 8*i -: 8];
            if (r > 0) begin
                for (int i = 0; i < 16; i++) a[i] = st[127 - 8*i -: 8];
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
                    b[4*c+1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
                    b[4*c+2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
                    b[4*c+3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
                end
                for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = b[i];
            end
        end
        return st;
    endfunction

    // One clock: sample at the falling edge and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        if (done) begin
            dones++;
            if (sb.size() == 0) begin
                check("unexpected_done", {127'b0, done}, 128'd0);
            end else begin
                e = sb.pop_front();
                check("cipher", cipher, e.ct);
                check("done_cycle", 128'(cyc), 128'(e.due));
                check("busy_at_done", {127'b0, busy}, 128'd0);
            end
            last_done_cyc = cyc;
        end
    endtask

    task automatic do_start(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct, input bit push);
        start     = 1'b1;
        plaintext = pt;
        secret    = key;
        if (push) sb.push_back('{ct, cyc + 11});
        tick();
        start     = 1'b0;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        secret    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = dones;
        n  = 0;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", {127'b0, (dones == d0)}, 128'd0);
    endtask

    initial begin
        int d0;
        int first_done;
        int n;

        build_sbox();
        reset     = 1'b1;
        start     = 1'b0;
        secret    = '0;
        plaintext = '0;
        tick();
        tick();
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        check("rst_cipher", cipher, 128'd0);
        check("rst_last_key", lastRoundKey, 128'd0);
        check("rst_rk_out", roundKeyOut, 128'd0);
        check("rst_rk_idx", 128'(roundKeyIndex), 128'd0);
        reset = 1'b0;
        tick();

        // Vector 1: FIPS-197 appendix C.1, latency checked by the scoreboard.
        do_start(PT1, KEY1, CT1, 1'b1);
        wait_done(20);

        // Vector 2: round key export and final round key.
        do_start(PT2, KEY2, CT2, 1'b1);
        check("busy_round1", {127'b0, busy}, 128'd1);
        check("rk_idx_1", 128'(roundKeyIndex), 128'd1);
        check("rk_out_1", roundKeyOut, RK1);
        wait_done(20);
        check("last_round_key", lastRoundKey, RK10);
        tick();
        check("idle_rk_out", roundKeyOut, 128'd0);
        check("idle_rk_idx", 128'(roundKeyIndex), 128'd0);

        // Start pulsed while busy with a different block must be ignored.
        d0 = dones;
        do_start(PT1, KEY1, CT1, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            start     = 1'b1;
            plaintext = 128'h0;
            secret    = KEY2;
            tick();
        end
        start = 1'b0;
        wait_done(20);
        repeat (15) tick();
        check("single_done", 128'(dones - d0), 128'd1);
        check("cipher_held", cipher, CT1);

        // Back-to-back: second start in the done cycle of the first.
        do_start(PT1, KEY1, CT1, 1'b1);
        wait_done(20);
        first_done = last_done_cyc;
        do_start(PT2, KEY2, CT2, 1'b1);
        wait_done(20);
        check("b2b_spacing", 128'(last_done_cyc - first_done), 128'd11);

        // Chain into an inverse cipher driven only by cipher and lastRoundKey.
        check("chain_plaintext", decrypt(cipher, lastRoundKey), PT2);
        check("chain_key", first_key(lastRoundKey), KEY2);

        // Reset at round 5 abandons the block immediately.
        do_start(PT1, KEY1, CT1, 1'b1);
        n = 0;
        while (roundKeyIndex != 4'd5 && n < 12) begin
            tick();
            n++;
        end
        check("reached_round5", 128'(roundKeyIndex), 128'd5);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", {127'b0, busy}, 128'd0);
        check("midrst_done", {127'b0, done}, 128'd0);
        check("midrst_cipher", cipher, 128'd0);
        check("midrst_last_key", lastRoundKey, 128'd0);
        check("midrst_rk_idx", 128'(roundKeyIndex), 128'd0);
        sb.delete();
        d0 = dones;
        tick();
        reset = 1'b0;
        repeat (15) tick();
        check("no_done_after_rst", 128'(dones - d0), 128'd0);
        do_start(PT1, KEY1, CT1, 1'b1);
        wait_done(20);
        check("cipher_after_rst", cipher, CT1);

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
